// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and state type for the instruction-fetch sequencer.
package riscv_fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic {FETCH_RUN, FETCH_HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc} holding register for instructions fetched during a stall.
module fetch_skid_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC, IF/ID register, stall skid and redirect squash around a
// one-cycle-latency synchronous instruction memory.
module fetch_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              IMEM_AW  = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    output logic [31:0]        instr_d_o,
    output logic [XLEN-1:0]    pc_d_o,
    output logic [XLEN-1:0]    pc_plus4_d_o,
    output logic               valid_d_o,
    output logic [XLEN-1:0]    pc_f_o,
    output logic               misalign_o,
    output logic [31:0]        bubble_cnt_o
);
    fetch_state_e    state;
    logic [XLEN-1:0] pc_f, inf_pc, skid_pc;
    logic [31:0]     skid_instr;
    logic            inf_vld, skid_vld, run, to_hold, release_id, next_run;

    assign run         = state == FETCH_RUN;
    assign to_hold     = run & stall_i & inf_vld;
    assign release_id  = !run & !stall_i;
    // The address presented this cycle advances only when its data will be used next cycle.
    assign next_run    = !(stall_i & (inf_vld | !run));
    assign imem_addr_o = pc_f[IMEM_AW+1:2];
    assign pc_f_o      = pc_f;

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (to_hold & !redirect_i),
        .clear      (redirect_i | release_id),
        .load_instr (imem_rdata_i),
        .load_pc    (inf_pc),
        .valid      (skid_vld),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH_RUN;
            pc_f         <= RESET_PC;
            inf_vld      <= 1'b0;
            inf_pc       <= '0;
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (redirect_i) begin
            state     <= FETCH_RUN;
            pc_f      <= {redirect_pc_i[XLEN-1:2], 2'b00};
            inf_vld   <= 1'b0;
            instr_d_o <= NOP_INSTR;
            valid_d_o <= 1'b0;
        end else begin
            state <= next_run ? FETCH_RUN : FETCH_HOLD;
            if (next_run)
                pc_f <= pc_f + XLEN'(4);
            if (run | !stall_i) begin
                inf_vld <= 1'b1;
                inf_pc  <= pc_f;
            end
            if (release_id) begin
                instr_d_o    <= skid_instr;
                pc_d_o       <= skid_pc;
                pc_plus4_d_o <= skid_pc + XLEN'(4);
                valid_d_o    <= skid_vld;
            end else if (run & !stall_i) begin
                instr_d_o    <= inf_vld ? imem_rdata_i : NOP_INSTR;
                pc_d_o       <= inf_pc;
                pc_plus4_d_o <= inf_pc + XLEN'(4);
                valid_d_o    <= inf_vld;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o   <= 1'b0;
            bubble_cnt_o <= '0;
        end else begin
            misalign_o <= redirect_i & |redirect_pc_i[1:0];
            if (!valid_d_o && !stall_i && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized bench comparing the IF/ID stream against an
// instruction-stream model (next PC to deliver plus remaining bubble cycles).
module tb_fetch_sequencer;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [63:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_d, bubble_cnt;
    logic [63:0] pc_d, pc_plus4_d, pc_f;
    logic        valid_d, misalign;

    int tests = 0;
    int fails = 0;

    logic        m_valid, m_mis;
    logic [63:0] m_pc, m_next;
    logic [31:0] m_cnt;
    int          m_wait;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .pc_plus4_d_o  (pc_plus4_d),
        .valid_d_o     (valid_d),
        .pc_f_o        (pc_f),
        .misalign_o    (misalign),
        .bubble_cnt_o  (bubble_cnt)
    );

    always #5 clk = ~clk;

    // IMEM contents: word n holds 0x00100093 + n.
    always @(posedge clk) imem_rdata <= 32'h00100093 + {24'd0, imem_addr};

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return 32'h00100093 + {24'd0, pc[9:2]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_next  = '0;
        m_wait  = 1;
        m_cnt   = '0;
        m_mis   = 1'b0;
    endtask

    // One clock edge of the stream model: redirects restart with one bubble before the target,
    // stalls freeze ID but still let a pending fetch complete.
    task automatic model_edge();
        if (!m_valid && !stall && m_cnt != '1)
            m_cnt++;
        m_mis = redirect && (redirect_pc[1:0] != 2'b00);
        if (redirect) begin
            m_valid = 1'b0;
            m_next  = {redirect_pc[63:2], 2'b00};
            m_wait  = 1;
        end else if (stall) begin
            if (m_wait > 0) m_wait--;
        end else if (m_wait > 0) begin
            m_valid = 1'b0;
            m_wait--;
        end else begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 64'd4;
        end
    endtask

    task automatic check_outputs();
        check("valid_d", {63'd0, valid_d}, {63'd0, m_valid});
        check("instr_d", {32'd0, instr_d}, {32'd0, m_valid ? word_at(m_pc) : NOP});
        if (m_valid) begin
            check("pc_d", pc_d, m_pc);
            check("pc_plus4_d", pc_plus4_d, m_pc + 64'd4);
        end
        check("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_cnt});
        check("misalign", {63'd0, misalign}, {63'd0, m_mis});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {63'd0, valid_d}, 64'd0);
        check({tag, "_instr"}, {32'd0, instr_d}, {32'd0, NOP});
        check({tag, "_pc_d"}, pc_d, 64'd0);
        check({tag, "_pc_plus4"}, pc_plus4_d, 64'd0);
        check({tag, "_pc_f"}, pc_f, 64'd0);
        check({tag, "_misalign"}, {63'd0, misalign}, 64'd0);
        check({tag, "_bubble"}, {32'd0, bubble_cnt}, 64'd0);
    endtask

    // Called at a negedge: drive inputs, take one rising edge, check at the next negedge.
    task automatic step(input logic s, input logic r, input logic [63:0] t);
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Startup stream then a 3-cycle stall while ID holds PC 8.
        repeat (4) step(1'b0, 1'b0, '0);
        check("hold_pc_8", pc_d, 64'h8);
        repeat (3) step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);

        // Redirect while running.
        step(1'b0, 1'b1, 64'h40);
        repeat (4) step(1'b0, 1'b0, '0);

        // Redirect together with stall while in HOLD.
        repeat (2) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 64'h40);
        repeat (4) step(1'b0, 1'b0, '0);

        // Misaligned redirect target.
        step(1'b0, 1'b1, 64'h42);
        repeat (4) step(1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of HOLD.
        repeat (2) step(1'b1, 1'b0, '0);
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        repeat (5) step(1'b0, 1'b0, '0);

        // PC wraps modulo 2^64.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (5) step(1'b0, 1'b0, '0);

        for (int i = 0; i < 600; i++) begin
            logic [63:0] t;
            t = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)}
                                             : {52'd0, 12'($urandom_range(0, 4095))};
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
